// File: rtl/result_pipeline_if.sv
// rtl/result_pipeline_if.sv - execute-side, memory and forwarding signal bundle for result_pipeline
interface result_pipeline_if;
    logic        valid_e;
    logic        reg_write_e;
    logic [4:0]  rd_e;
    logic [2:0]  result_src_e;
    logic [31:0] alu_result_e;
    logic [31:0] pc_plus4_e;
    logic [31:0] imm_ext_e;
    logic [31:0] pc_target_e;
    logic [31:0] rd1_e;
    logic [31:0] rd2_e;
    logic [1:0]  forward_ae;
    logic [1:0]  forward_be;
    logic [31:0] read_data_m;
    logic [31:0] src_a_e;
    logic [31:0] src_b_e;
    logic [4:0]  rd_m;
    logic [4:0]  rd_w;
    logic [4:0]  rd_b;
    logic        reg_write_m;
    logic        reg_write_w;
    logic        reg_write_b;
    logic [31:0] result_w;
    logic [31:0] alu_result_m;
    logic        load_fwd_m;

    modport master (
        output valid_e, reg_write_e, rd_e, result_src_e, alu_result_e, pc_plus4_e,
               imm_ext_e, pc_target_e, rd1_e, rd2_e, forward_ae, forward_be, read_data_m,
        input  src_a_e, src_b_e, rd_m, rd_w, rd_b, reg_write_m, reg_write_w, reg_write_b,
               result_w, alu_result_m, load_fwd_m
    );

    modport slave (
        input  valid_e, reg_write_e, rd_e, result_src_e, alu_result_e, pc_plus4_e,
               imm_ext_e, pc_target_e, rd1_e, rd2_e, forward_ae, forward_be, read_data_m,
        output src_a_e, src_b_e, rd_m, rd_w, rd_b, reg_write_m, reg_write_w, reg_write_b,
               result_w, alu_result_m, load_fwd_m
    );
endinterface

// File: rtl/result_pipeline.sv
// rtl/result_pipeline.sv - M/W/B result stages with operand forwarding muxes
// Optional macro LOAD_FWD_M_EN: forward load data (read_data_m) from M instead of early_m.
module result_pipeline (
    input logic              clk,
    input logic              rst,
    result_pipeline_if.slave bus
);
    logic [4:0]  rd_m, rd_w, rd_b;
    logic        reg_write_m, reg_write_w, reg_write_b;
    logic [2:0]  result_src_m;
    logic [31:0] alu_result_m, early_m;
    logic [31:0] result_w, result_b;
    logic [31:0] early_e;
    logic [31:0] result_m_final;
    logic [31:0] fwd_m;
    logic        reg_write_e_ok;

    always_comb begin
        early_e = bus.alu_result_e;
        case (bus.result_src_e)
            3'b010:  early_e = bus.pc_plus4_e;
            3'b011:  early_e = bus.imm_ext_e;
            3'b100:  early_e = bus.pc_target_e;
            default: early_e = bus.alu_result_e;
        endcase
    end

    // Flushed instructions and x0 targets never become architectural writes.
    assign reg_write_e_ok = bus.reg_write_e & bus.valid_e & (bus.rd_e != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_m         <= 5'd0;
            rd_w         <= 5'd0;
            rd_b         <= 5'd0;
            reg_write_m  <= 1'b0;
            reg_write_w  <= 1'b0;
            reg_write_b  <= 1'b0;
            result_src_m <= 3'd0;
            alu_result_m <= 32'd0;
            early_m      <= 32'd0;
            result_w     <= 32'd0;
            result_b     <= 32'd0;
        end else begin
            rd_m         <= bus.rd_e;
            reg_write_m  <= reg_write_e_ok;
            result_src_m <= bus.result_src_e;
            alu_result_m <= bus.alu_result_e;
            early_m      <= early_e;
            rd_w         <= rd_m;
            reg_write_w  <= reg_write_m;
            result_w     <= result_m_final;
            rd_b         <= rd_w;
            reg_write_b  <= reg_write_w;
            result_b     <= result_w;
        end
    end

    assign result_m_final = (result_src_m == 3'b001) ? bus.read_data_m : early_m;

`ifdef LOAD_FWD_M_EN
    assign fwd_m = result_m_final;
`else
    // Without the late load path a load in M forwards its address; load_fwd_m flags it.
    assign fwd_m = early_m;
`endif

    always_comb begin
        bus.src_a_e = bus.rd1_e;
        case (bus.forward_ae)
            2'b10:   bus.src_a_e = fwd_m;
            2'b01:   bus.src_a_e = result_w;
            2'b11:   bus.src_a_e = result_b;
            default: bus.src_a_e = bus.rd1_e;
        endcase
    end

    always_comb begin
        bus.src_b_e = bus.rd2_e;
        case (bus.forward_be)
            2'b10:   bus.src_b_e = fwd_m;
            2'b01:   bus.src_b_e = result_w;
            2'b11:   bus.src_b_e = result_b;
            default: bus.src_b_e = bus.rd2_e;
        endcase
    end

    assign bus.load_fwd_m = ((bus.forward_ae == 2'b10) || (bus.forward_be == 2'b10))
                            && (result_src_m == 3'b001) && reg_write_m;

    assign bus.rd_m         = rd_m;
    assign bus.rd_w         = rd_w;
    assign bus.rd_b         = rd_b;
    assign bus.reg_write_m  = reg_write_m;
    assign bus.reg_write_w  = reg_write_w;
    assign bus.reg_write_b  = reg_write_b;
    assign bus.result_w     = result_w;
    assign bus.alu_result_m = alu_result_m;
endmodule

// File: tb/tb_result_pipeline.sv
// tb/tb_result_pipeline.sv - scoreboard bench for result_pipeline
module tb_result_pipeline;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    result_pipeline_if bus ();
    result_pipeline dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    function automatic logic [31:0] model_result(input logic [2:0] src, input logic [31:0] alu,
                                                 input logic [31:0] pc4, input logic [31:0] imm,
                                                 input logic [31:0] tgt, input logic [31:0] rdata);
        case (src)
            3'b001:  return rdata;
            3'b010:  return pc4;
            3'b011:  return imm;
            3'b100:  return tgt;
            default: return alu;
        endcase
    endfunction

    // Drive one instruction into E, clock it into M, retire the scoreboard entry now in W.
    task automatic step(input logic v, input logic we, input logic [4:0] rd, input logic [2:0] src,
                        input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm,
                        input logic [31:0] tgt, input logic [31:0] rdata);
        sb_t e;
        bus.forward_ae   = 2'b00;
        bus.forward_be   = 2'b00;
        bus.valid_e      = v;
        bus.reg_write_e  = we;
        bus.rd_e         = rd;
        bus.result_src_e = src;
        bus.alu_result_e = alu;
        bus.pc_plus4_e   = pc4;
        bus.imm_ext_e    = imm;
        bus.pc_target_e  = tgt;
        e.rd   = rd;
        e.we   = v && we && (rd != 5'd0);
        e.data = model_result(src, alu, pc4, imm, tgt, rdata);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 2) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (bus.result_w !== e.data || bus.rd_w !== e.rd || bus.reg_write_w !== e.we) begin
                n_err++;
                $display("FAIL sb_w result_w=%h rd_w=%0d we_w=%b exp %h %0d %b",
                         bus.result_w, bus.rd_w, bus.reg_write_w, e.data, e.rd, e.we);
            end
        end
        bus.read_data_m = rdata;
    endtask

    task automatic bubble();
        step(1'b0, 1'b0, 5'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic pulse_reset();
        rst              = 1'b1;
        bus.valid_e      = 1'b1;
        bus.reg_write_e  = 1'b1;
        bus.rd_e         = 5'd5;
        bus.alu_result_e = 32'h1234_5678;
        bus.forward_ae   = 2'b00;
        bus.forward_be   = 2'b00;
        @(posedge clk);
        #1;
        sb_q.delete();
        bus.read_data_m = 32'h0;
    endtask

    task automatic check_cleared(input string tag);
        n_cmp++;
        if ({bus.reg_write_m, bus.reg_write_w, bus.reg_write_b} !== 3'b000) begin
            n_err++;
            $display("FAIL %s reg_write_mwb=%b exp 000", tag,
                     {bus.reg_write_m, bus.reg_write_w, bus.reg_write_b});
        end
        n_cmp++;
        if ({bus.rd_m, bus.rd_w, bus.rd_b} !== 15'd0 || bus.result_w !== 32'h0) begin
            n_err++;
            $display("FAIL %s rd_m/w/b=%0d/%0d/%0d result_w=%h exp 0", tag,
                     bus.rd_m, bus.rd_w, bus.rd_b, bus.result_w);
        end
    endtask

    task automatic check_fwd_zero(input string tag);
        for (int s = 1; s < 4; s++) begin
            bus.forward_ae = 2'(s);
            #1;
            n_cmp++;
            if (bus.src_a_e !== 32'h0) begin
                n_err++;
                $display("FAIL %s fwd=%0d src_a_e=%h exp 0", tag, s, bus.src_a_e);
            end
        end
        bus.forward_ae = 2'b00;
    endtask

    task automatic test_reset();
        bus.rd1_e = 32'hA5A5_0001;
        bus.rd2_e = 32'h5A5A_0002;
        pulse_reset();
        check_cleared("reset");
        n_cmp++;
        if (bus.src_a_e !== 32'hA5A5_0001 || bus.src_b_e !== 32'h5A5A_0002) begin
            n_err++;
            $display("FAIL reset_comb src_a_e=%h src_b_e=%h exp A5A50001 5A5A0002",
                     bus.src_a_e, bus.src_b_e);
        end
        rst = 1'b0;
        check_fwd_zero("reset_fwd");
    endtask

    task automatic test_alu_chain();
        step(1'b1, 1'b1, 5'd3, 3'b000, 32'h10, 32'h0, 32'h0, 32'h0, 32'h0);
        bus.forward_ae = 2'b10; #1;
        n_cmp++;
        if (bus.src_a_e !== 32'h10) begin n_err++; $display("FAIL alu_fwd_m src_a_e=%h exp 10", bus.src_a_e); end
        bubble();
        bus.forward_ae = 2'b01; #1;
        n_cmp++;
        if (bus.src_a_e !== 32'h10) begin n_err++; $display("FAIL alu_fwd_w src_a_e=%h exp 10", bus.src_a_e); end
        bubble();
        bus.forward_ae = 2'b11; #1;
        n_cmp++;
        if (bus.src_a_e !== 32'h10 || bus.rd_b !== 5'd3 || bus.reg_write_b !== 1'b1) begin
            n_err++;
            $display("FAIL alu_fwd_b src_a_e=%h rd_b=%0d we_b=%b exp 10 3 1", bus.src_a_e, bus.rd_b, bus.reg_write_b);
        end
        bubble();
        bus.forward_ae = 2'b11; #1;
        n_cmp++;
        if (bus.src_a_e !== 32'h0) begin n_err++; $display("FAIL alu_gone src_a_e=%h exp 0", bus.src_a_e); end
    endtask

    task automatic test_jal();
        step(1'b1, 1'b1, 5'd1, 3'b010, 32'h55, 32'h104, 32'h77, 32'h88, 32'h0);
        bus.forward_ae = 2'b10; #1;
        n_cmp++;
        if (bus.reg_write_m !== 1'b1 || bus.src_a_e !== 32'h104) begin
            n_err++;
            $display("FAIL jal_m we_m=%b src_a_e=%h exp 1 104", bus.reg_write_m, bus.src_a_e);
        end
        bubble();
    endtask

    task automatic test_load();
        step(1'b1, 1'b1, 5'd7, 3'b001, 32'h200, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF);
        bus.forward_be = 2'b10; #1;
        n_cmp++;
`ifdef LOAD_FWD_M_EN
        if (bus.src_b_e !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL load_fwd src_b_e=%h exp DEADBEEF", bus.src_b_e); end
`else
        if (bus.src_b_e !== 32'h200) begin n_err++; $display("FAIL load_fwd src_b_e=%h exp 200", bus.src_b_e); end
`endif
        n_cmp++;
        if (bus.load_fwd_m !== 1'b1 || bus.alu_result_m !== 32'h200) begin
            n_err++;
            $display("FAIL load_flag load_fwd_m=%b alu_result_m=%h exp 1 200", bus.load_fwd_m, bus.alu_result_m);
        end
        bus.forward_be = 2'b01; #1;
        n_cmp++;
        if (bus.load_fwd_m !== 1'b0) begin n_err++; $display("FAIL load_flag_off load_fwd_m=%b exp 0", bus.load_fwd_m); end
        bubble();
    endtask

    task automatic test_x0_bubble();
        step(1'b1, 1'b1, 5'd0, 3'b000, 32'h99, 32'h0, 32'h0, 32'h0, 32'h0);
        n_cmp++;
        if (bus.reg_write_m !== 1'b0) begin n_err++; $display("FAIL x0_write we_m=%b exp 0", bus.reg_write_m); end
        step(1'b0, 1'b1, 5'd4, 3'b000, 32'h98, 32'h0, 32'h0, 32'h0, 32'h0);
        n_cmp++;
        if (bus.reg_write_m !== 1'b0 || bus.rd_m !== 5'd4) begin
            n_err++;
            $display("FAIL bubble_write we_m=%b rd_m=%0d exp 0 4", bus.reg_write_m, bus.rd_m);
        end
        bubble();
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b1, 5'd9, 3'b000, 32'hA, 32'h0, 32'h0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 5'd9, 3'b011, 32'h0, 32'h0, 32'hB, 32'h0, 32'h0);
        step(1'b1, 1'b1, 5'd9, 3'b100, 32'h0, 32'h0, 32'h0, 32'hC, 32'h0);
        for (int s = 1; s < 4; s++) begin
            logic [31:0] exp_v;
            exp_v = (s == 2) ? 32'hC : (s == 1) ? 32'hB : 32'hA;
            bus.forward_ae = 2'(s);
            bus.forward_be = 2'(s);
            #1;
            n_cmp++;
            if (bus.src_a_e !== exp_v || bus.src_b_e !== exp_v) begin
                n_err++;
                $display("FAIL b2b fwd=%0d src_a_e=%h src_b_e=%h exp %h", s, bus.src_a_e, bus.src_b_e, exp_v);
            end
        end
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom), 3'($urandom),
                 $urandom, $urandom, $urandom, $urandom, $urandom);
        end
        bubble();
    endtask

    task automatic test_midstream_reset();
        step(1'b1, 1'b1, 5'd11, 3'b000, 32'h111, 32'h0, 32'h0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 5'd12, 3'b001, 32'h222, 32'h0, 32'h0, 32'h0, 32'h333);
        step(1'b1, 1'b1, 5'd13, 3'b010, 32'h0, 32'h444, 32'h0, 32'h0, 32'h0);
        pulse_reset();
        rst = 1'b0;
        check_cleared("mid_reset");
        check_fwd_zero("mid_reset_fwd");
        step(1'b1, 1'b1, 5'd14, 3'b000, 32'h555, 32'h0, 32'h0, 32'h0, 32'h0);
        bubble();
    endtask

    initial begin
        bus.valid_e = 1'b0; bus.reg_write_e = 1'b0; bus.rd_e = 5'd0; bus.result_src_e = 3'd0;
        bus.alu_result_e = 32'h0; bus.pc_plus4_e = 32'h0; bus.imm_ext_e = 32'h0; bus.pc_target_e = 32'h0;
        bus.rd1_e = 32'h0; bus.rd2_e = 32'h0; bus.forward_ae = 2'b00; bus.forward_be = 2'b00;
        bus.read_data_m = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_alu_chain();
        test_jal();
        test_load();
        test_x0_bubble();
        test_back_to_back();
        test_midstream_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/result_pipeline.md
RESULT_PIPELINE -- requirements
Module: result_pipeline

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have execute-side inputs: valid_e  in  1  instr in E is real; reg_write_e  in  1; rd_e  in  5; result_src_e  in  3; alu_result_e  in  32; pc_plus4_e  in  32; imm_ext_e  in  32; pc_target_e  in  32.
REQ-003 SHALL have forwarding inputs: rd1_e  in  32 regfile rs1 data; rd2_e  in  32 regfile rs2 data; forward_ae  in  2; forward_be  in  2 (from hazard unit).
REQ-004 SHALL have memory input: read_data_m  in  32  asynchronous data-memory read for the M-stage access.
REQ-005 SHALL have outputs: src_a_e  out  32; src_b_e  out  32  forwarded operands; rd_m, rd_w, rd_b  out  5 each; reg_write_m, reg_write_w, reg_write_b  out  1 each; result_w  out  32  regfile write data; alu_result_m  out  32  memory address; load_fwd_m  out  1  M-stage load forwarded this cycle.

Function
REQ-006 SHALL hold three register stages M, W, B, each capturing the previous stage every clk edge; no stall, no enable.
REQ-007 SHALL capture into M: rd_e, result_src_e, alu_result_e, and early_e, where early_e = alu_result_e (000, 001), pc_plus4_e (010), imm_ext_e (011), pc_target_e (100); codes 101-111 select alu_result_e.
REQ-008 SHALL load reg_write_m = reg_write_e AND valid_e AND (rd_e != 0); x0 writes never propagate.
REQ-009 SHALL compute result_m_final = read_data_m when result_src_m==001, else early_m; W captures result_m_final, rd_m, reg_write_m.
REQ-010 SHALL capture into B: result_w, rd_w, reg_write_w unchanged; B models the value written to the regfile one cycle earlier.
REQ-011 SHALL drive result_w, rd_w, reg_write_w directly from W registers; regfile write occurs at the edge ending W.
REQ-012 SHALL select src_a_e by forward_ae: 00 rd1_e, 10 M-stage forward value, 01 result_w, 11 result_b; src_b_e identically by forward_be with rd2_e.
REQ-013 SHALL form the M-stage forward value per Configuration; all forwarding paths combinational, zero added latency.
REQ-014 SHALL assert load_fwd_m when (forward_ae==10 or forward_be==10) and result_src_m==001 and reg_write_m.
REQ-015 Latency: value produced in E at cycle n is on result_w at n+2, on result_b at n+3, gone after n+3.
REQ-016 Back-to-back writes to the same rd SHALL keep per-stage values distinct; priority is resolved solely by the forward selects.
REQ-017 valid_e low (bubble, flushed instr) SHALL clear reg_write in M; data fields may still capture.

Reset
REQ-018 On rst at a clk edge SHALL clear reg_write_m/w/b, rd_m/w/b, result_src_m, all 32-bit stage registers to 0.
REQ-019 Reset mid-operation SHALL discard all in-flight results in the same edge; first cycle after rst deasserts, all forward values are 0 and reg_write_* are 0.
REQ-020 src_a_e/src_b_e SHALL remain combinational during reset (reflect rd1_e/rd2_e when selects are 00).

Configuration
REQ-021 Macro LOAD_FWD_M_EN: defined -> M-stage forward value = result_m_final (load data forwarded from M via read_data_m).
REQ-022 Undefined -> M-stage forward value = early_m (load forwards its address); load_fwd_m flags the illegal case; all else identical.

Verification
REQ-023 Reset: rst=1 one edge with reg_write_e=1, rd_e=5 -> next cycle reg_write_m/w/b=0, rd_*=0, result_w=0.
REQ-024 ALU chain: E addi rd=3 alu_result_e=0x10, next cycle forward_ae=10 -> src_a_e=0x10; two cycles later forward_ae=01 -> 0x10; three later forward_ae=11 -> 0x10.
REQ-025 JAL rd=1 pc_plus4_e=0x104, result_src_e=010 -> reg_write_m=1, forward 10 yields 0x104, result_w=0x104 at n+2.
REQ-026 Load rd=7, alu_result_e=0x200, read_data_m=0xDEADBEEF, forward_be=10 next cycle -> with LOAD_FWD_M_EN src_b_e=0xDEADBEEF; without, src_b_e=0x200 and load_fwd_m=1; both result_w=0xDEADBEEF at n+2.
REQ-027 Writes to x0 (rd_e=0, reg_write_e=1) and valid_e=0 instructions -> reg_write_m=0 in both cases.
REQ-028 Mid-stream rst with three instructions in M/W/B -> all reg_write_* 0 the next cycle, no stale result_w.
